ram_bank: RTL and testbench
===========================

# ram_bank

Parametrised single-port synchronous RAM bank with per-byte write enables, a configurable read latency and an optional write-through read. It contains a hardware clear engine: the async reset cannot reach the storage array, so the engine zeroes every word after reset and on request. The bank is the general memory building block for the datapath. It replaces fixed 256×64 RAM instances and keeps their cen/wen semantics.

## Interface
- DATA_W, 64, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width.
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2.
- WRITE_THROUGH, 0, controls dout on a write cycle: 1 returns the merged written word, 0 holds dout.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cen  in  1  chip enable.
- wen  in  1  write enable; qualified by cen.
- be  in  DATA_W/8  byte enables for writes; be[i] covers din[8i+7:8i].
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- clr  in  1  single-cycle pulse that starts a full clear sweep.
- dout  out  DATA_W  read data.
- rvalid  out  1  dout carries a valid read result this cycle.
- busy  out  1  clear engine is active; host accesses are ignored.

## Operation
- Per-cycle access, decided at the edge, in priority order:
  - busy=1: no array write; stage-1 result is 0 and not valid.
  - cen=0: stage-1 result is 0 and not valid.
  - cen=1, wen=0: stage-1 result is mem[addr] and valid.
  - cen=1, wen=1: mem[addr] is updated on enabled bytes only (bytes with be[i]=1 take din; other bytes keep their old value).
    - WRITE_THROUGH=1: stage-1 result is the merged word and valid.
    - WRITE_THROUGH=0: stage-1 holds its previous data and is not valid.
  - cen=1, wen=1, be=0: no change to the array. The response is the same as any other write cycle.
- Out-of-range address (addr ≥ DEPTH):
  - a write is dropped;
  - a read returns 0 with rvalid=1.
- Output stage:
  - READ_LAT=1: dout and rvalid are the stage-1 register.
  - READ_LAT=2: one extra register stage follows stage 1, and dout and rvalid come from it.
- Clear engine FSM has two states, IDLE and CLEAR.
  - While reset_n is low: state=CLEAR, counter=0.
  - In CLEAR, with reset_n high: each cycle writes mem[counter]=0 and then increments the counter.
  - After writing DEPTH-1, the next edge moves the FSM to IDLE.
  - IDLE to CLEAR: on clr=1, with the counter reset to 0.
  - clr=1 during CLEAR restarts the sweep at 0.
  - busy = (state==CLEAR).

## Timing
- Reset values:
  - dout=0, rvalid=0, busy=1.
  - The extra stage registers (READ_LAT=2) are also 0.
  - The clear counter is 0.
- After reset_n rises, the sweep takes exactly DEPTH cycles. busy falls on the edge after the write to DEPTH-1 (DEPTH=256 gives 256 busy cycles after release).
- A read issued at edge T has dout and rvalid valid after edge T+READ_LAT-1, i.e. they are sampled at edge T+READ_LAT. rvalid is high for exactly one cycle per read.
- Back-to-back reads are fully pipelined: one result per cycle, no bubbles.
- Read on the cycle after a write to the same address returns the new data.
- With READ_LAT=2, a cen=0 cycle clears dout two cycles later. A read already in flight still completes.
- A clr pulse is accepted on its own edge. The first cleared word is written on the next edge, and busy is high from the next cycle.
- A host access on the same edge as clr is still performed.
- reset_n asserted mid-sweep or mid-read:
  - outputs go to their reset values immediately (asynchronously);
  - the sweep restarts from 0 after release;
  - in-flight reads are lost.

## Structure
- Shared package ram_pkg holds:
  - the clear-state enum (IDLE, CLEAR);
  - the byte-mask expansion function (be to a bit mask);
  - the READ_LAT legality check.
- One sub-module, ram_clear_fsm, holds the state register, counter and busy, and outputs the clear write address and enable.
- The top level holds:
  - the array, with no reset on the array;
  - the write muxing between host and clear engine;
  - the output pipeline.

## Test plan
1. Reset then sweep:
   - Prime mem[5] with nonzero data, assert reset_n low, release, wait DEPTH=256 cycles.
   - busy high for 256 cycles then low; a read of address 5 returns 0 with rvalid=1.
2. Byte-enable write:
   - Write 0x1111_2222_3333_4444 to addr 3 with be=0xFF.
   - Then write din=0xAAAA_BBBB_CCCC_DDDD to addr 3 with be=0x0F.
   - Read addr 3 returns 0x1111_2222_CCCC_DDDD.
3. Read latency:
   - READ_LAT=2, back-to-back reads of addrs 0, 1, 2.
   - rvalid high on three consecutive cycles starting two cycles after the first request, data in order.
4. Write-through:
   - WRITE_THROUGH=1: write 0xDEAD to addr 7; dout=0xDEAD with rvalid=1 one cycle later.
   - WRITE_THROUGH=0: dout unchanged and rvalid=0.
5. Clear during access:
   - clr pulse while reads stream.
   - Reads issued during busy give rvalid=0 and dout=0.
   - After busy falls, all addresses read back 0.
6. Reset mid-sweep and out-of-range:
   - reset_n low at sweep count 100: dout=0 and rvalid=0 immediately, and the sweep restarts at 0.
   - With DEPTH=200, a write to addr 250 is dropped, and a read of 250 returns 0 with rvalid=1.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the ram_bank memory building block.
//   clr_state_t    : clear-engine states (IDLE, CLEAR)
//   byte_mask()    : expands one byte-enable bit into an 8-bit lane mask
//   read_lat_legal : returns 1 for the supported read latencies (1 or 2)
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // One byte-enable bit becomes a full lane of the write mask; the top
  // level applies this per lane to build the DATA_W-wide mask.
  function automatic logic [7:0] byte_mask(input logic en);
    return {8{en}};
  endfunction

  function automatic bit read_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm
// Clear engine for ram_bank. Sweeps every word of the array to zero after
// reset release and whenever clr is pulsed.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (forces CLEAR, counter 0)
//   clr      in   pulse that (re)starts a sweep at word 0
//   busy     out  sweep in progress
//   clr_we   out  clear write enable for the array
//   clr_addr out  word being cleared this cycle
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] count, count_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // The word at count is zeroed on the same edge that advances the
  // counter; leaving CLEAR coincides with the write of the last word, so
  // a full sweep keeps busy high for exactly DEPTH cycles. clr wins over
  // everything and restarts at word 0.
  always_comb begin
    state_next = state;
    count_next = count;
    if (state == CLEAR) begin
      if (count == LAST) begin
        state_next = IDLE;
        count_next = '0;
      end else begin
        count_next = count + 1'b1;
      end
    end
    if (clr) begin
      state_next = CLEAR;
      count_next = '0;
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = count;

endmodule

// File: rtl/ram_bank.sv
// ram_bank
// Single-port synchronous RAM bank with per-byte write enables, 1- or
// 2-cycle read latency, optional write-through read and a hardware clear
// engine (the storage array itself has no reset).
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   cen      in   chip enable
//   wen      in   write enable (qualified by cen)
//   be       in   byte enables, be[i] covers din[8i+7:8i]
//   addr     in   word address
//   din      in   write data
//   clr      in   pulse starting a full clear sweep
//   dout     out  read data
//   rvalid   out  dout holds a valid read result this cycle
//   busy     out  clear engine active, host accesses ignored
module ram_bank
  import ram_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int READ_LAT      = 1,
  parameter int WRITE_THROUGH = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cen,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("ram_bank: READ_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic              in_range;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic              host_wr;

  // Addresses at or beyond DEPTH read as zero and never reach the array.
  assign in_range = ({1'b0, addr} < DEPTH_LIM);

  always_comb begin
    mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = byte_mask(be[i]);
    end
  end

  assign old_word = in_range ? mem[addr] : '0;
  assign merged   = (old_word & ~mask) | (din & mask);
  assign host_wr  = !busy && cen && wen && in_range;

  // The clear engine owns the array while busy; host writes are already
  // blocked then, so the two write sources never collide.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (host_wr) begin
      mem[addr] <= merged;
    end
  end

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;

  // Stage 1: a non-write-through write keeps the old data but drops valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (busy || !cen) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else if (!wen) begin
      s1_data  <= old_word;
      s1_valid <= 1'b1;
    end else if (WRITE_THROUGH != 0) begin
      s1_data  <= merged;
      s1_valid <= 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_data  <= s1_data;
        s2_valid <= s1_valid;
      end
    end

    assign dout   = s2_data;
    assign rvalid = s2_valid;
  end else begin : g_lat1
    assign dout   = s1_data;
    assign rvalid = s1_valid;
  end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank
// Drives two ram_bank instances from one stimulus stream:
//   dut_a : DEPTH=256, READ_LAT=1, WRITE_THROUGH=0
//   dut_b : DEPTH=200, READ_LAT=2, WRITE_THROUGH=1
// and compares them each cycle against a behavioural model of the bank.
module tb_ram_bank;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        wen;
  logic [7:0]  be;
  logic [7:0]  addr;
  logic [63:0] din;
  logic        clr;

  logic [63:0] dout_a, dout_b;
  logic        rvalid_a, rvalid_b;
  logic        busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  ram_bank #(
    .DATA_W(64), .DEPTH(256), .READ_LAT(1), .WRITE_THROUGH(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be),
    .addr(addr), .din(din), .clr(clr),
    .dout(dout_a), .rvalid(rvalid_a), .busy(busy_a)
  );

  ram_bank #(
    .DATA_W(64), .DEPTH(200), .READ_LAT(2), .WRITE_THROUGH(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .be(be),
    .addr(addr), .din(din), .clr(clr),
    .dout(dout_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: memory contents, sweep position (== depth when no
  // sweep is running) and the last two per-edge results.
  int          depth_m [2] = '{256, 200};
  int          lat_m   [2] = '{1, 2};
  bit          wt_m    [2] = '{1'b0, 1'b1};
  logic [63:0] mem_m   [2][256];
  int          sweep_m [2];
  logic [63:0] hist_d  [2][2];
  logic        hist_v  [2][2];

  task automatic modelReset(input int k);
    sweep_m[k]   = 0;
    hist_d[k][0] = '0;
    hist_d[k][1] = '0;
    hist_v[k][0] = 1'b0;
    hist_v[k][1] = 1'b0;
  endtask

  task automatic modelEdge(input int k);
    logic [63:0] mask, word, merged, rd;
    logic        rv;
    bit          was_busy, inr;
    was_busy = sweep_m[k] < depth_m[k];
    inr      = int'(addr) < depth_m[k];
    for (int i = 0; i < 8; i++) mask[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    word   = inr ? mem_m[k][addr] : 64'h0;
    merged = (word & ~mask) | (din & mask);
    rd = 64'h0;
    rv = 1'b0;
    if (was_busy || !cen) begin
      rd = 64'h0;
      rv = 1'b0;
    end else if (!wen) begin
      rd = word;
      rv = 1'b1;
    end else begin
      if (inr) mem_m[k][addr] = merged;
      if (wt_m[k]) begin
        rd = merged;
        rv = 1'b1;
      end else begin
        rd = hist_d[k][0];
        rv = 1'b0;
      end
    end
    if (was_busy) begin
      mem_m[k][sweep_m[k]] = 64'h0;
      sweep_m[k]++;
    end
    if (clr) sweep_m[k] = 0;
    hist_d[k][1] = hist_d[k][0];
    hist_v[k][1] = hist_v[k][0];
    hist_d[k][0] = rd;
    hist_v[k][0] = rv;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int k = 0; k < 2; k++) begin
      logic [63:0] od;
      logic        ov, ob;
      od = (k == 0) ? dout_a : dout_b;
      ov = (k == 0) ? rvalid_a : rvalid_b;
      ob = (k == 0) ? busy_a : busy_b;
      checkValue($sformatf("%s dut%0d dout", tag, k), od, hist_d[k][lat_m[k]-1]);
      checkValue($sformatf("%s dut%0d rvalid", tag, k), {63'h0, ov}, {63'h0, hist_v[k][lat_m[k]-1]});
      checkValue($sformatf("%s dut%0d busy", tag, k), {63'h0, ob},
                 {63'h0, (sweep_m[k] < depth_m[k])});
    end
  endtask

  task automatic applyStimulus(input string tag, input bit c, input bit w,
                               input logic [7:0] b_en, input logic [7:0] a,
                               input logic [63:0] d, input bit cl);
    cen  = c;
    wen  = w;
    be   = b_en;
    addr = a;
    din  = d;
    clr  = cl;
    for (int k = 0; k < 2; k++) begin
      if (reset_n) modelEdge(k);
      else modelReset(k);
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0, 1'b0);
  endtask

  task automatic readAt(input string tag, input logic [7:0] a);
    applyStimulus(tag, 1'b1, 1'b0, 8'h00, a, 64'h0, 1'b0);
  endtask

  task automatic writeAt(input string tag, input logic [7:0] a, input logic [63:0] d,
                         input logic [7:0] b_en);
    applyStimulus(tag, 1'b1, 1'b1, b_en, a, d, 1'b0);
  endtask

  // Asynchronous reset taken mid-cycle: outputs must drop before any edge.
  task automatic asyncReset(input string tag);
    reset_n = 1'b0;
    #1;
    checkValue({tag, " async dout_a"}, dout_a, 64'h0);
    checkValue({tag, " async rvalid_a"}, {63'h0, rvalid_a}, 64'h0);
    checkValue({tag, " async busy_a"}, {63'h0, busy_a}, 64'h1);
    checkValue({tag, " async dout_b"}, dout_b, 64'h0);
    checkValue({tag, " async rvalid_b"}, {63'h0, rvalid_b}, 64'h0);
    for (int k = 0; k < 2; k++) modelReset(k);
    idle({tag, " held"});
    reset_n = 1'b1;
  endtask

  // Counts busy samples from release (one before the first edge) until idle.
  task automatic sweepAndCount(input string tag);
    int ca, cb;
    ca = busy_a ? 1 : 0;
    cb = busy_b ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      idle({tag, " sweep"});
      if (busy_a) ca++;
      if (busy_b) cb++;
    end
    checkValue({tag, " busy cycles a"}, 64'(ca), 64'd256);
    checkValue({tag, " busy cycles b"}, 64'(cb), 64'd200);
  endtask

  logic [63:0] v [3];
  logic [63:0] cap_d [5];
  logic        cap_v [5];
  logic [63:0] held;

  initial begin
    reset_n = 1'b0;
    cen = 0; wen = 0; be = 0; addr = 0; din = 0; clr = 0;
    for (int k = 0; k < 2; k++) begin
      modelReset(k);
      for (int i = 0; i < 256; i++) mem_m[k][i] = 64'h0;
    end
    @(posedge clk);
    #1;
    idle("reset");
    idle("reset");
    reset_n = 1'b1;
    sweepAndCount("first sweep");

    // Reset then sweep, with a read in flight when reset hits.
    writeAt("prime", 8'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    readAt("prime read", 8'd5);
    checkValue("prime dout_a", dout_a, 64'h0123_4567_89AB_CDEF);
    asyncReset("mid read");
    sweepAndCount("second sweep");
    readAt("read 5 after sweep", 8'd5);
    checkValue("swept mem5 dout_a", dout_a, 64'h0);
    checkValue("swept mem5 rvalid_a", {63'h0, rvalid_a}, 64'h1);
    idle("read 5 drain");
    checkValue("swept mem5 rvalid_b", {63'h0, rvalid_b}, 64'h1);

    // Byte-enable merge.
    writeAt("be full", 8'd3, 64'h1111_2222_3333_4444, 8'hFF);
    writeAt("be low", 8'd3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    readAt("be read", 8'd3);
    checkValue("be merge dout_a", dout_a, 64'h1111_2222_CCCC_DDDD);
    writeAt("be none", 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    readAt("be none read", 8'd3);
    checkValue("be zero keeps word", dout_a, 64'h1111_2222_CCCC_DDDD);

    // Read latency and pipelining.
    v[0] = 64'hA0A0_0000_0000_0001;
    v[1] = 64'hB1B1_0000_0000_0002;
    v[2] = 64'hC2C2_0000_0000_0003;
    for (int i = 0; i < 3; i++) writeAt("lat fill", 8'(i), v[i], 8'hFF);
    idle("lat gap");
    idle("lat gap");
    for (int i = 0; i < 5; i++) begin
      if (i < 3) readAt("lat read", 8'(i));
      else idle("lat drain");
      cap_d[i] = dout_b;
      cap_v[i] = rvalid_b;
      if (i < 3) checkValue("lat1 data a", dout_a, v[i]);
    end
    checkValue("lat2 rvalid e1", {63'h0, cap_v[0]}, 64'h0);
    checkValue("lat2 rvalid e2", {63'h0, cap_v[1]}, 64'h1);
    checkValue("lat2 rvalid e3", {63'h0, cap_v[2]}, 64'h1);
    checkValue("lat2 rvalid e4", {63'h0, cap_v[3]}, 64'h1);
    checkValue("lat2 rvalid e5", {63'h0, cap_v[4]}, 64'h0);
    checkValue("lat2 data 0", cap_d[1], v[0]);
    checkValue("lat2 data 1", cap_d[2], v[1]);
    checkValue("lat2 data 2", cap_d[3], v[2]);

    // Write-through versus hold.
    readAt("wt pre read", 8'd1);
    held = dout_a;
    writeAt("wt write", 8'd7, 64'h0000_0000_0000_DEAD, 8'hFF);
    checkValue("hold dout_a", dout_a, held);
    checkValue("hold rvalid_a", {63'h0, rvalid_a}, 64'h0);
    idle("wt drain");
    checkValue("wt dout_b", dout_b, 64'h0000_0000_0000_DEAD);
    checkValue("wt rvalid_b", {63'h0, rvalid_b}, 64'h1);

    // Clear while reads stream.
    for (int i = 0; i < 10; i++) begin
      applyStimulus("clr stream", 1'b1, 1'b0, 8'h00, 8'(i), 64'h0, i == 4);
      if (i == 4) checkValue("clr edge read done", {63'h0, rvalid_a}, 64'h1);
      if (i >= 5) begin
        checkValue("busy read rvalid_a", {63'h0, rvalid_a}, 64'h0);
        checkValue("busy read dout_a", dout_a, 64'h0);
      end
    end
    for (int i = 0; i < 300 && (busy_a || busy_b); i++) readAt("clr wait", 8'(i));
    checkValue("clr finished", {63'h0, busy_a | busy_b}, 64'h0);
    for (int i = 0; i < 256; i++) begin
      readAt("clr readback", 8'(i));
      checkValue("cleared word a", dout_a, 64'h0);
      checkValue("cleared rvalid a", {63'h0, rvalid_a}, 64'h1);
    end

    // Reset mid-sweep.
    writeAt("pre sweep", 8'd150, 64'hFEED_FACE_0000_1234, 8'hFF);
    applyStimulus("clr pulse", 1'b1, 1'b0, 8'h00, 8'd150, 64'h0, 1'b1);
    for (int i = 0; i < 300 && sweep_m[0] != 100; i++) idle("to count 100");
    checkValue("sweep at 100", 64'(sweep_m[0]), 64'd100);
    asyncReset("mid sweep");
    sweepAndCount("restart sweep");
    readAt("read 150", 8'd150);
    checkValue("restart cleared 150", dout_a, 64'h0);

    // Out-of-range on the 200-word bank.
    writeAt("oor write", 8'd250, 64'h5555_6666_7777_8888, 8'hFF);
    readAt("oor read", 8'd250);
    checkValue("oor in range on a", dout_a, 64'h5555_6666_7777_8888);
    idle("oor drain");
    checkValue("oor dout_b", dout_b, 64'h0);
    checkValue("oor rvalid_b", {63'h0, rvalid_b}, 64'h1);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      bit          c, w, cl;
      logic [7:0]  a;
      logic [63:0] d;
      c  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      cl = ($urandom_range(0, 299) == 0);
      d  = {$urandom, $urandom};
      if (w) a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 199));
      else   a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      applyStimulus("random", c, w, 8'($urandom_range(0, 255)), a, d, cl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
